// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Parses SYNC, LEN, payload[LEN] (and a trailing XOR checksum byte when
//   FRAME_CHECKSUM_EN is defined) from a UART receiver's byte stream, buffers
//   the payload and replays it as a valid/ready stream with a last marker.
//
//   Build option: define FRAME_CHECKSUM_EN to add the CSUM state and its check.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   rx_data    received byte            rx_valid  level, byte not yet consumed
//   rx_clear   one-cycle pulse after each accepted byte (receiver soft reset)
//   out_data   payload byte             out_valid / out_ready  handshake
//   out_last   final payload byte       frame_len  LEN of frame in delivery
//   err        one-cycle error pulse    err_code   00 overrun, 01 bad length,
//                                                  10 checksum, 11 timeout
module uart_frame_parser #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_clear,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int            IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]    LMAX = 8'(MAX_LEN);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DELIVER} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_DELIVER} state_t;
`endif

    state_t          r_state, w_state_nxt;
    logic            r_rx_valid_q;
    logic [CW-1:0]   r_tcnt;
    logic [7:0]      r_len, r_wr_idx, r_rd_idx;
    logic [7:0]      r_buf [MAX_LEN];
    logic            r_rx_clear, r_out_valid, r_out_last, r_err;
    logic [7:0]      r_out_data, r_frame_len;
    logic [1:0]      r_err_code;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            w_accept, w_counting, w_timeout, w_err_set;
    logic [1:0]      w_err_code_nxt;
    logic [7:0]      w_rd_nxt;

    // Only the 0->1 edge of rx_valid is a new byte; a held level is ignored.
    assign w_accept   = rx_valid & ~r_rx_valid_q;
    assign w_counting = (r_state == S_LEN) || (r_state == S_PAYLOAD)
`ifdef FRAME_CHECKSUM_EN
                        || (r_state == S_CSUM)
`endif
                        ;
    // An accepted byte in the expiry cycle beats the timeout.
    assign w_timeout  = w_counting && !w_accept && (r_tcnt == TMAX);
    assign w_rd_nxt   = r_rd_idx + 8'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_err_set      = 1'b0;
        w_err_code_nxt = 2'b00;
        case (r_state)
            S_IDLE: if (w_accept && rx_data == SYNC_BYTE) w_state_nxt = S_LEN;
            S_LEN: if (w_accept) begin
                if (rx_data == 8'd0 || rx_data > LMAX) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = 2'b01;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: if (w_accept && r_wr_idx == r_len - 8'd1) begin
`ifdef FRAME_CHECKSUM_EN
                w_state_nxt = S_CSUM;
`else
                w_state_nxt = S_DELIVER;
`endif
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: if (w_accept) begin
                if (rx_data == r_csum) begin
                    w_state_nxt = S_DELIVER;
                end else begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = 2'b10;
                    w_state_nxt    = S_IDLE;
                end
            end
`endif
            S_DELIVER: begin
                if (w_accept) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = 2'b00;
                end
                if (r_out_valid && out_ready && r_out_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_err_set      = 1'b1;
            w_err_code_nxt = 2'b11;
            w_state_nxt    = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rx_valid_q <= 1'b0;
            r_tcnt       <= '0;
            r_len        <= '0;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_rx_clear   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_frame_len  <= '0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_rx_valid_q <= rx_valid;
            r_rx_clear   <= w_accept;
            r_err        <= w_err_set;
            if (w_err_set) r_err_code <= w_err_code_nxt;

            if (w_accept || !w_counting) r_tcnt <= '0;
            else                         r_tcnt <= r_tcnt + 1'b1;

            if (r_state == S_LEN && w_state_nxt == S_PAYLOAD) begin
                r_len       <= rx_data;
                r_frame_len <= rx_data;
                r_wr_idx    <= '0;
                r_rd_idx    <= '0;
`ifdef FRAME_CHECKSUM_EN
                r_csum      <= rx_data;
`endif
            end
            if (r_state == S_PAYLOAD && w_accept) begin
                r_wr_idx <= r_wr_idx + 8'd1;
`ifdef FRAME_CHECKSUM_EN
                r_csum   <= r_csum ^ rx_data;
`endif
            end

            // First beat loads the cycle after entering DELIVER; each accepted
            // beat preloads the next so transfers run at one byte per cycle.
            if (r_state == S_DELIVER) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_buf[r_rd_idx[IW-1:0]];
                    r_out_last  <= (r_rd_idx == r_len - 8'd1);
                end else if (out_ready) begin
                    if (r_out_last) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else begin
                        r_rd_idx   <= w_rd_nxt;
                        r_out_data <= r_buf[w_rd_nxt[IW-1:0]];
                        r_out_last <= (w_rd_nxt == r_len - 8'd1);
                    end
                end
            end else begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && w_accept) r_buf[r_wr_idx[IW-1:0]] <= rx_data;
    end

    assign rx_clear  = r_rx_clear;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign frame_len = r_frame_len;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

    localparam int TMO = 40;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_clear;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frame_len;
    logic       err;
    logic [1:0] err_code;

    uart_frame_parser #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_clear(rx_clear), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frame_len(frame_len),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int err_cnt = 0;
    logic [1:0] last_code = 2'b00;
    logic [7:0] cap_d[$];
    bit         cap_l[$];
    int         cap_c[$];
    logic [7:0] cap_fl[$];

    always @(posedge clk) cyc++;

    // Sampled mid-cycle: out_valid && out_ready here means a transfer at the next edge.
    always @(negedge clk) begin
        if (rx_clear) clr_cnt++;
        if (err) begin
            err_cnt++;
            last_code = err_code;
        end
        if (out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_l.push_back(out_last);
            cap_c.push_back(cyc);
            cap_fl.push_back(frame_len);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic cap_clear();
        cap_d.delete(); cap_l.delete(); cap_c.delete(); cap_fl.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int e0, c0;

    initial begin
        rst = 1'b0; rx_data = '0; rx_valid = 1'b0; out_ready = 1'b1;
        idle(3);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last",  32'(out_last), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_frame_len", 32'(frame_len), 0);
        chk("rst_rx_clear",  32'(rx_clear), 0);
        chk("rst_err",       32'(err), 0);
        chk("rst_err_code",  32'(err_code), 0);
        rst = 1'b1;
        idle(2);

        // Basic frame, back-to-back delivery
        cap_clear(); e0 = err_cnt; c0 = clr_cnt;
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        if (CS) send_byte(8'h03);
        idle(10);
        chk("f1_count", cap_d.size(), 3);
        chk("f1_d0", 32'(cap_d[0]), 32'h11);
        chk("f1_d1", 32'(cap_d[1]), 32'h22);
        chk("f1_d2", 32'(cap_d[2]), 32'h33);
        chk("f1_last", {cap_l[0], cap_l[1], cap_l[2]}, 3'b001);
        chk("f1_b2b", cap_c[2] - cap_c[0], 2);
        chk("f1_len", 32'(cap_fl[0]), 3);
        chk("f1_err", err_cnt - e0, 0);
        chk("f1_clr", clr_cnt - c0, CS ? 6 : 5);
        chk("f1_idle_valid", 32'(out_valid), 0);

        // Bad checksum (checksum build) / plain two-byte frame otherwise
        cap_clear(); e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'h00);
        idle(6);
        if (CS) begin
            chk("csum_err", err_cnt - e0, 1);
            chk("csum_code", 32'(last_code), 2);
            chk("csum_noout", cap_d.size(), 0);
        end else begin
            chk("nocs_err", err_cnt - e0, 0);
            chk("nocs_count", cap_d.size(), 2);
            chk("nocs_last", 32'(cap_l[1]), 1);
        end

        // Zero length after a dropped non-sync byte
        cap_clear(); e0 = err_cnt;
        send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h00);
        idle(3);
        chk("len0_err", err_cnt - e0, 1);
        chk("len0_code", 32'(last_code), 1);
        // Length just above MAX_LEN
        e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h11);
        idle(3);
        chk("len17_err", err_cnt - e0, 1);
        chk("len17_code", 32'(last_code), 1);
        chk("len_noout", cap_d.size(), 0);

        // Length exactly MAX_LEN: payload 0..15, xor of payload is 0
        cap_clear(); e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        if (CS) send_byte(8'h10);
        idle(24);
        chk("max_count", cap_d.size(), 16);
        chk("max_d15", 32'(cap_d[15]), 32'h0F);
        chk("max_last15", 32'(cap_l[15]), 1);
        chk("max_last14", 32'(cap_l[14]), 0);
        chk("max_err", err_cnt - e0, 0);

        // Timeout mid-payload
        cap_clear(); e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        idle(TMO - 5);
        chk("tmo_early", err_cnt - e0, 0);
        idle(20);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_code", 32'(last_code), 3);
        chk("tmo_noout", cap_d.size(), 0);
        e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        idle(6);
        chk("post_tmo_count", cap_d.size(), 1);
        chk("post_tmo_d0", 32'(cap_d[0]), 32'h7E);
        chk("post_tmo_last", 32'(cap_l[0]), 1);
        chk("post_tmo_err", err_cnt - e0, 0);

        // Backpressure with an overrun byte
        cap_clear(); out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55); send_byte(8'h66);
        if (CS) send_byte(8'h31);
        idle(3);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_data", 32'(out_data), 32'h55);
        chk("bp_last", 32'(out_last), 0);
        e0 = err_cnt; c0 = clr_cnt;
        send_byte(8'h99);
        idle(12);
        chk("ovr_err", err_cnt - e0, 1);
        chk("ovr_code", 32'(last_code), 0);
        chk("ovr_clr", clr_cnt - c0, 1);
        chk("bp_hold_data", 32'(out_data), 32'h55);
        chk("bp_hold_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        idle(6);
        chk("bp_count", cap_d.size(), 2);
        chk("bp_d1", 32'(cap_d[1]), 32'h66);
        chk("bp_l1", 32'(cap_l[1]), 1);

        // Level held high accepted once
        c0 = clr_cnt;
        @(posedge clk); #1 rx_data = 8'h42; rx_valid = 1'b1;
        idle(50);
        rx_valid = 1'b0;
        idle(2);
        chk("hold_clr", clr_cnt - c0, 1);

        // Reset mid-payload
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_flen", 32'(frame_len), 0);
        chk("mid_rst_code", 32'(err_code), 0);
        chk("mid_rst_err", 32'(err), 0);
        idle(2);
        rst = 1'b1;
        idle(2);
        cap_clear(); e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hC3);
        if (CS) send_byte(8'hC2);
        idle(6);
        chk("post_rst_count", cap_d.size(), 1);
        chk("post_rst_d0", 32'(cap_d[0]), 32'hC3);
        chk("post_rst_len", 32'(cap_fl[0]), 1);
        chk("post_rst_err", err_cnt - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
